// File: rtl/mux_pkg.sv
// Shared definitions for the lane mux and its demux counterpart: state encoding,
// default geometry and the lane-index width helper.
package mux_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int NUM_LANES_DEF = 4;
    localparam int CTRL_W_DEF    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mux_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_lane_cnt.sv
// Lane select counter: cleared when a frame is captured, advances once per
// emitted lane and wraps naturally because NUM_LANES is a power of two.
module mux_lane_cnt import mux_pkg::*; #(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int SEL_W     = clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             last_o
);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    // Next select value: clear has priority over increment.
    always_comb begin
        sel_d = sel_q;
        if (clr_i) begin
            sel_d = '0;
        end else if (en_i) begin
            sel_d = sel_q + SEL_W'(1);
        end else begin
            sel_d = sel_q;
        end
    end

    // Select register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o  = sel_q;
    assign last_o = (sel_q == SEL_W'(NUM_LANES - 1));

endmodule

// File: rtl/mux_lanes.sv
// Serializes one frame of parallel lane bytes onto a single byte stream, one lane
// per cycle, tagged with its lane index. Optional parity output: MUX_PARITY_EN.
module mux_lanes import mux_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int CTRL_W    = CTRL_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_L,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    input  logic [NUM_LANES-1:0]        valid_in,
    output logic                        load_ready,
    output logic [DATA_W-1:0]           data_out,
    output logic                        valid_out,
    output logic [CTRL_W-1:0]           control
`ifdef MUX_PARITY_EN
    ,
    output logic                        parity_out
`endif
);

    localparam int SEL_W = clog2(NUM_LANES);

    mux_state_e                  state_q;
    logic [NUM_LANES*DATA_W-1:0] frame_q;
    logic [NUM_LANES-1:0]        fvalid_q;
    logic [DATA_W-1:0]           data_q;
    logic                        valid_q;
    logic [CTRL_W-1:0]           control_q;

    logic [SEL_W-1:0]            sel_s;
    logic                        last_s;
    logic                        run_s;
    logic                        capture_s;
    logic [DATA_W-1:0]           lanes_s [NUM_LANES];
    logic [DATA_W-1:0]           lane_byte_s;
    logic                        lane_vld_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane_view
        assign lanes_s[g] = frame_q[g*DATA_W +: DATA_W];
    end

    assign run_s       = (state_q == ST_RUN);
    assign load_ready  = (state_q == ST_IDLE) || (run_s && last_s);
    assign capture_s   = load_ready && (|valid_in);
    assign lane_byte_s = lanes_s[sel_s];
    assign lane_vld_s  = fvalid_q[sel_s];

    mux_lane_cnt #(
        .NUM_LANES (NUM_LANES),
        .SEL_W     (SEL_W)
    ) u_lane_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .clr_i   (capture_s),
        .en_i    (run_s),
        .sel_o   (sel_s),
        .last_o  (last_s)
    );

`ifdef MUX_PARITY_EN
    logic parity_q;

    function automatic logic even_par(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction
`endif

    // Frame capture, state sequencing and registered lane outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            fvalid_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            control_q <= '0;
`ifdef MUX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            if (capture_s) begin
                frame_q  <= data_in;
                fvalid_q <= valid_in;
            end else begin
                frame_q  <= frame_q;
                fvalid_q <= fvalid_q;
            end
            case (state_q)
                ST_IDLE: begin
                    data_q    <= '0;
                    valid_q   <= 1'b0;
                    control_q <= '0;
`ifdef MUX_PARITY_EN
                    parity_q  <= 1'b0;
`endif
                    state_q   <= capture_s ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    // Invalid lanes still occupy their slot with a zero byte.
                    data_q    <= lane_vld_s ? lane_byte_s : '0;
                    valid_q   <= lane_vld_s;
                    control_q <= CTRL_W'(sel_s);
`ifdef MUX_PARITY_EN
                    parity_q  <= lane_vld_s ? even_par(lane_byte_s) : 1'b0;
`endif
                    if (last_s && !capture_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    data_q    <= '0;
                    valid_q   <= 1'b0;
                    control_q <= '0;
`ifdef MUX_PARITY_EN
                    parity_q  <= 1'b0;
`endif
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign control   = control_q;
`ifdef MUX_PARITY_EN
    assign parity_out = parity_q;
`endif

endmodule

// File: doc/mux_lanes.md
Name: mux_lanes

Overview:
- Transmit-side counterpart of the lane demux.
- Accepts one frame of NUM_LANES parallel bytes with per-lane valids.
- Time-interleaves the frame onto a single byte stream, one lane per clk cycle, tagging each byte with its lane index on control.
- Sits upstream of the demux: mux_lanes data_out/valid_out/control feed the demux data_in/valid_in.

Parameters:
- DATA_W, 8, width of each lane byte and of data_out.
- NUM_LANES, 4, lanes per frame; power of two, minimum 2.
- CTRL_W, 8, width of control; lane index is zero-extended into it.

Ports:
- clk  in  1  single clock (fast rate).
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  NUM_LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W].
- valid_in  in  NUM_LANES  per-lane valid; bit i qualifies lane i.
- load_ready  out  1  a frame is sampled at the next clk edge if any valid_in bit is set.
- data_out  out  DATA_W  serialized byte; 0 when the lane is invalid or the block is idle.
- valid_out  out  1  data_out carries a valid lane byte.
- control  out  CTRL_W  lane index of the current data_out.
- parity_out  out  1  present only with MUX_PARITY_EN.

Behaviour:
- Reset (reset_L low, asynchronous, including mid-frame):
  - data_out=0, valid_out=0, control=0, parity_out=0.
  - state=IDLE, sel=0, frame and fvalid registers=0.
  - Any frame in flight is discarded.
- Release: the first active edge is evaluated from IDLE.
- States: IDLE, RUN. Internal regs are frame[NUM_LANES], fvalid, and sel (log2(NUM_LANES) bits).
- load_ready = (state==IDLE) || (state==RUN && sel==NUM_LANES-1). Combinational from registers only.
- Capture condition = load_ready && |valid_in. On that edge:
  - frame<=data_in, fvalid<=valid_in, sel<=0, state<=RUN.
- IDLE, no capture: data_out<=0, valid_out<=0, control<=0.
- RUN, every edge:
  - data_out<=fvalid[sel] ? frame[sel] : 0.
  - valid_out<=fvalid[sel].
  - control<=sel (zero-extended).
  - sel<=sel+1, wrapping NUM_LANES-1 -> 0.
- RUN at sel==NUM_LANES-1:
  - The last lane is emitted on this edge.
  - If the capture condition holds, the next frame loads on the same edge and lane 0 follows with no gap.
  - Otherwise state<=IDLE, and outputs go to 0 on the following edge.
- Latency: lane k of a frame appears on the outputs k+1 edges after the capture edge. A frame occupies exactly NUM_LANES output cycles.
- Invalid lanes keep their time slot: control still advances, and valid_out=0, data_out=0.
- data_in/valid_in are ignored while load_ready is low. Upstream must hold a frame until it observes load_ready high at an edge.
- valid_in all-zero while load_ready is high: no capture; from RUN the block drops to IDLE.

Optional Feature:
- MUX_PARITY_EN defined:
  - Port parity_out is added.
  - Registered with data_out: parity_out = ^data_out (even parity over the emitted byte), 0 whenever valid_out is 0.
- MUX_PARITY_EN undefined: port and logic are absent; remaining behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - State enum encoding (IDLE=0, RUN=1).
  - Lane-index width function clog2(NUM_LANES).
  - Default DATA_W/NUM_LANES/CTRL_W constants, shared with the demux.
- One sub-module: mux_lane_cnt.
  - Sel counter with synchronous clear-on-capture, increment, and wrap.
  - last flag = (sel==NUM_LANES-1).
  - Async reset_L.

Test Plan:
- Reset mid-frame: drive reset_L low while control==2. Outputs read 0 immediately, before the next edge. After release with valid_in=0, valid_out stays 0.
- Single full frame: data_in={8'hDD,8'hCC,8'hBB,8'hAA}, valid_in=4'hF, from IDLE. The next 4 output cycles show AA/0, BB/1, CC/2, DD/3 (data/control) with valid_out=1. Then valid_out=0, data_out=0.
- Partial valid: valid_in=4'b0101, lanes {44,33,22,11}. Outputs are 11 v=1, 00 v=0, 33 v=1, 00 v=0, with control 0..3.
- Back-to-back: a second frame {88,77,66,55} is presented while load_ready is high at sel==3. Lane 0 (55) follows lane 3 (DD) with no idle cycle, and valid_out stays high for 8 consecutive cycles.
- Backpressure: data_in is changed while load_ready=0 at sel==1. Outputs are unaffected, and only the value present at the load_ready edge is captured.
- MUX_PARITY_EN: emitted byte 8'h07 gives parity_out=1; 8'h03 gives parity_out=0; invalid slot gives parity_out=0.
